// File: rtl/l1_port_arbiter_if.sv
// L1 fetch/data requester signals and backing-memory handshake shared by l1_port_arbiter.
// master: arbiter view; slave: requesters plus memory view.
interface l1_port_arbiter_if;
  logic        Ireq;
  logic [31:0] Iaddr;
  logic [31:0] Iinstn;
  logic        Iwait;
  logic        Dmemaccess;
  logic        Dwe;
  logic [31:0] Daddr;
  logic [31:0] Dwritedata;
  logic [31:0] Dreaddata;
  logic        Dwait;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  Ireq, Iaddr, Dmemaccess, Dwe, Daddr, Dwritedata, mem_rdata, mem_ready,
    output Iinstn, Iwait, Dreaddata, Dwait, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output Ireq, Iaddr, Dmemaccess, Dwe, Daddr, Dwritedata, mem_rdata, mem_ready,
    input  Iinstn, Iwait, Dreaddata, Dwait, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l1_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports, one access at a time, with timeout.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: D priority).
module l1_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  l1_port_arbiter_if.master     bus,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

  localparam logic [15:0] TermCnt = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] iinstn_q, iinstn_d;
  logic [31:0] dread_q, dread_d;
  logic        err_q, err_d;

  logic        busy, abort, done;
  logic        i_done, d_done, d_rd_done;
  logic [31:0] rsp_data;
  logic        grant_d, grant_i;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^{bus.Iaddr[1:0], bus.Daddr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;  // 1 when D was the most recent grant

  assign grant_d = bus.Dmemaccess & (~bus.Ireq | ~last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == StIdle) begin
      if (grant_d) begin
        last_d_d = 1'b1;
      end else if (grant_i) begin
        last_d_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign grant_d = bus.Dmemaccess;
`endif

  assign grant_i = bus.Ireq & ~grant_d;

  // Completion outranks the terminal count; nothing completes while reset is held.
  assign busy      = (state_q != StIdle);
  assign abort     = busy & ~reset & ~bus.mem_ready & (cnt_q == TermCnt);
  assign done      = busy & ~reset & (bus.mem_ready | abort);
  assign i_done    = done & (state_q == StIBusy);
  assign d_done    = done & (state_q == StDBusy);
  assign d_rd_done = d_done & ~we_q;
  assign rsp_data  = bus.mem_ready ? bus.mem_rdata : 32'h0;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    iinstn_d = iinstn_q;
    dread_d  = dread_q;
    err_d    = err_q | abort;

    case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d = StDBusy;
          addr_d  = bus.Daddr[31:2];
          we_d    = bus.Dwe;
          wdata_d = bus.Dwritedata;
          cnt_d   = '0;
        end else if (grant_i) begin
          state_d = StIBusy;
          addr_d  = bus.Iaddr[31:2];
          we_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      StIBusy, StDBusy: begin
        if (done) begin
          state_d = StIdle;
        end else begin
          cnt_d = 16'(cnt_q + 16'd1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A requester that has already dropped its request gets nothing latched.
    if (i_done && bus.Ireq) begin
      iinstn_d = rsp_data;
    end
    if (d_rd_done && bus.Dmemaccess) begin
      dread_d = rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      iinstn_q <= '0;
      dread_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      iinstn_q <= iinstn_d;
      dread_q  <= dread_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    bus.mem_req   = busy;
    bus.mem_we    = (state_q == StDBusy) & we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.Iwait     = bus.Ireq & ~i_done;
    bus.Dwait     = bus.Dmemaccess & ~d_done;
    bus.Iinstn    = i_done ? rsp_data : iinstn_q;
    bus.Dreaddata = d_rd_done ? rsp_data : dread_q;
    err_timeout   = err_q;
  end

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Directed plus randomized bench for l1_port_arbiter against a transaction-level reference model.
module tb_l1_port_arbiter;
  localparam int TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;
  logic err_timeout;
  l1_port_arbiter_if bus ();

  l1_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Stimulus knobs
  logic        rst, ireq, dreq, dwe, idle_rdy;
  logic [31:0] iaddr, daddr, dwdata;
  int          next_lat;  // busy cycle (1-based) in which memory answers; 0 = never

  // Reference model: owner 0 none, 1 fetch, 2 data; lastg 1 fetch, 2 data
  int          own, n, lat, lastg;
  logic [31:0] cap_addr, cap_wdata, ilast, dlast;
  logic        cap_we, err_m;
  logic [31:0] mem [logic [29:0]];
  logic        irel, drel, any_done;

  // Values sampled from the DUT in the latest cycle
  logic        s_iwait, s_dwait, s_mem_req, s_mem_we, s_err;
  logic [31:0] s_iinstn, s_drd, s_wdata;
  logic [29:0] s_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return {2'b00, w} ^ 32'hA5A5_0000;
  endfunction

  task automatic cyc();
    logic        busy, rdy, abrt, done_c, d_wins;
    logic [31:0] rdata, e_iinstn, e_drd;
    busy   = (own != 0);
    rdy    = busy ? (lat != 0 && n + 1 == lat) : idle_rdy;
    abrt   = busy && !rdy && (n + 1 == TO);
    done_c = busy && (rdy || abrt) && !rst;
    rdata  = (busy && rdy) ? memval(cap_addr[31:2]) : $urandom;

    reset          = rst;
    bus.Ireq       = ireq;
    bus.Iaddr      = iaddr;
    bus.Dmemaccess = dreq;
    bus.Dwe        = dwe;
    bus.Daddr      = daddr;
    bus.Dwritedata = dwdata;
    bus.mem_ready  = rdy;
    bus.mem_rdata  = rdata;
    #3;
    s_iwait = bus.Iwait;  s_dwait = bus.Dwait;  s_mem_req = bus.mem_req;
    s_mem_we = bus.mem_we; s_err = err_timeout; s_iinstn = bus.Iinstn;
    s_drd = bus.Dreaddata; s_wdata = bus.mem_wdata; s_addr = bus.mem_addr;

    e_iinstn = (own == 1 && done_c) ? (rdy ? rdata : 32'h0) : ilast;
    e_drd    = (own == 2 && done_c && !cap_we) ? (rdy ? rdata : 32'h0) : dlast;
    chk("Iwait", s_iwait, ireq && !(own == 1 && done_c));
    chk("Dwait", s_dwait, dreq && !(own == 2 && done_c));
    chk("Iinstn", s_iinstn, e_iinstn);
    chk("Dreaddata", s_drd, e_drd);
    chk("mem_req", s_mem_req, busy);
    chk("err_timeout", s_err, err_m);
    if (busy) begin
      chk("mem_addr", s_addr, cap_addr[31:2]);
      chk("mem_we", s_mem_we, own == 2 && cap_we);
      if (own == 2 && cap_we) chk("mem_wdata", s_wdata, cap_wdata);
    end
    irel = (own == 1 && done_c);
    drel = (own == 2 && done_c);
    any_done = done_c;

    @(posedge clk);
    if (rst) begin
      own = 0; n = 0; cap_addr = 0; cap_we = 0; cap_wdata = 0;
      ilast = 0; dlast = 0; err_m = 0; lastg = 1;
    end else if (busy) begin
      if (done_c) begin
        if (own == 1) ilast = e_iinstn;
        if (own == 2) dlast = e_drd;
        if (own == 2 && cap_we && rdy) mem[cap_addr[31:2]] = cap_wdata;
        if (abrt) err_m = 1'b1;
        own = 0;
      end else begin
        n++;
      end
    end else begin
      d_wins = dreq && (!ireq || !RR || lastg == 1);
      if (d_wins) begin
        own = 2; cap_addr = daddr; cap_we = dwe; cap_wdata = dwdata; lastg = 2;
      end else if (ireq) begin
        own = 1; cap_addr = iaddr; cap_we = 1'b0; lastg = 1;
      end
      n = 0;
      lat = next_lat;
    end
    #1;
  endtask

  task automatic run_to_done(output int nb);
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      nb += int'(s_mem_req);
      if (any_done) break;
    end
  endtask

  initial begin
    logic [29:0] got [3];
    logic [29:0] want [3];
    int nb;
    rst = 1; ireq = 0; dreq = 0; dwe = 0; idle_rdy = 0;
    iaddr = 0; daddr = 0; dwdata = 0; next_lat = 1;
    own = 0; n = 0; lat = 0; lastg = 1; cap_addr = 0; cap_wdata = 0; cap_we = 0;
    ilast = 0; dlast = 0; err_m = 0; irel = 0; drel = 0; any_done = 0;
    mem[30'h4] = 32'h0050_0093;
    reset = 1; bus.Ireq = 0; bus.Iaddr = 0; bus.Dmemaccess = 0; bus.Dwe = 0;
    bus.Daddr = 0; bus.Dwritedata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values, with a fetch request pending during reset
    ireq = 1; iaddr = 32'h10;
    cyc();
    chk("rst_iwait", s_iwait, 1);      chk("rst_mem_req", s_mem_req, 0);
    chk("rst_mem_addr", s_addr, 0);    chk("rst_mem_we", s_mem_we, 0);
    chk("rst_mem_wdata", s_wdata, 0);  chk("rst_iinstn", s_iinstn, 0);
    chk("rst_dreaddata", s_drd, 0);    chk("rst_err", s_err, 0);
    rst = 0;

    // Single fetch, memory answers one cycle after mem_req rises
    next_lat = 2;
    cyc(); chk("fetch_grant_wait", s_iwait, 1); chk("fetch_grant_noreq", s_mem_req, 0);
    cyc(); chk("fetch_b1_wait", s_iwait, 1); chk("fetch_addr", s_addr, 30'h4);
    chk("fetch_we", s_mem_we, 0);
    cyc(); chk("fetch_release", s_iwait, 0); chk("fetch_data", s_iinstn, 32'h0050_0093);
    ireq = 0;
    cyc(); chk("fetch_hold", s_iinstn, 32'h0050_0093);

    // Store then load
    dreq = 1; dwe = 1; daddr = 32'h100; dwdata = 32'hCAFE_F00D; next_lat = 1;
    run_to_done(nb);
    chk("store_we", s_mem_we, 1); chk("store_wdata", s_wdata, 32'hCAFE_F00D);
    chk("store_rd_unchanged", s_drd, 0); chk("store_release", s_dwait, 0);
    dreq = 0; cyc();
    dreq = 1; dwe = 0; next_lat = 3;
    run_to_done(nb);
    chk("load_data", s_drd, 32'hCAFE_F00D);
    dreq = 0; cyc(); chk("load_hold", s_drd, 32'hCAFE_F00D);

    // Ready on the terminal-count cycle: completion wins
    dreq = 1; dwe = 0; daddr = 32'h10; next_lat = TO;
    run_to_done(nb);
    chk("coinc_busy_cycles", nb, TO); chk("coinc_data", s_drd, 32'h0050_0093);
    dreq = 0; cyc(); chk("coinc_no_err", s_err, 0);

    // Simultaneous requests held for three accesses
    rst = 1; cyc(); rst = 0;
    ireq = 1; iaddr = 32'h200; dreq = 1; dwe = 0; daddr = 32'h300; next_lat = 1;
    for (int a = 0; a < 3; a++) begin
      run_to_done(nb);
      got[a] = s_addr;
      if (drel) daddr += 4;
    end
    if (!RR) chk("fixed_iwait_held", s_iwait, 1);
    ireq = 0; dreq = 0; cyc();
    want[0] = 30'hC0;
    want[1] = RR ? 30'h80 : 30'hC1;
    want[2] = RR ? 30'hC1 : 30'hC2;
    for (int a = 0; a < 3; a++) chk($sformatf("grant_order_%0d", a), got[a], want[a]);

    // Timeout: memory never answers
    dreq = 1; dwe = 0; daddr = 32'h100; next_lat = 0;
    run_to_done(nb);
    chk("to_busy_cycles", nb, TO); chk("to_dwait", s_dwait, 0); chk("to_data", s_drd, 0);
    dreq = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(); chk("to_err_sticky", s_err, 1);
    end

    // Reset in the second busy cycle, stray ready afterwards
    dreq = 1; dwe = 0; daddr = 32'h104; next_lat = 3;
    cyc(); cyc();
    rst = 1; cyc(); chk("rstmid_dwait", s_dwait, 1);
    rst = 0; dreq = 0; idle_rdy = 1;
    cyc(); chk("rstmid_req", s_mem_req, 0); chk("rstmid_data", s_drd, 0);
    chk("rstmid_err", s_err, 0);
    idle_rdy = 0;
    cyc(); chk("rstmid_ignored", s_drd, 0);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      if (!ireq || irel) begin
        ireq  = ($urandom % 4) != 0;
        iaddr = $urandom & 32'h0000_00FF;
      end
      if (!dreq || drel) begin
        dreq   = ($urandom % 3) != 0;
        dwe    = $urandom % 2;
        daddr  = $urandom & 32'h0000_00FF;
        dwdata = $urandom;
      end
      next_lat = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, TO));
      idle_rdy = $urandom % 2;
      rst      = ($urandom % 97) == 0;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
